sync_fifo_prog: RTL

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/sync_fifo_prog.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with registered full/empty/almost flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through with a one-word output stage.
module sync_fifo_prog #(
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH_WIDTH = 11,
    parameter int AF_THRESH        = 2**FIFO_DEPTH_WIDTH - 4,
    parameter int AE_THRESH        = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write,
    input  logic                        read,
    input  logic [DATA_WIDTH-1:0]       data_write,
    output logic [DATA_WIDTH-1:0]       data_read,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [FIFO_DEPTH_WIDTH:0]   data_count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW    = FIFO_DEPTH_WIDTH;
    localparam int CW    = FIFO_DEPTH_WIDTH + 1;
    localparam int DEPTH = 2**FIFO_DEPTH_WIDTH;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;
    logic [CW-1:0]         r_wptr;
    logic [CW-1:0]         r_rptr;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_af;
    logic                  r_ae;
    logic                  r_ovf;
    logic                  r_udf;

    logic [CW-1:0]         w_wptr_nxt;
    logic [CW-1:0]         w_rptr_nxt;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_rd_adv;
    logic                  w_empty_nxt;

    assign w_wr_en    = write & ~r_full;
    assign w_rd_en    = read & ~r_empty;
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_wr_en};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_rd_adv};

`ifdef SYNC_FIFO_FWFT_EN
    // The output stage counts as stored: total = words in RAM + staged word.
    logic r_ovalid;
    logic w_ovalid_nxt;
    logic w_mem_empty;

    assign w_mem_empty  = (r_wptr == r_rptr);
    assign w_rd_adv     = ~w_mem_empty & (~r_ovalid | w_rd_en);
    assign w_ovalid_nxt = w_rd_adv | (r_ovalid & ~w_rd_en);
    assign w_count      = (r_wptr - r_rptr) + {{AW{1'b0}}, r_ovalid};
    assign w_count_nxt  = (w_wptr_nxt - w_rptr_nxt) + {{AW{1'b0}}, w_ovalid_nxt};
    assign w_empty_nxt  = ~w_ovalid_nxt;
`else
    assign w_rd_adv     = w_rd_en;
    assign w_count      = r_wptr - r_rptr;
    assign w_count_nxt  = w_wptr_nxt - w_rptr_nxt;
    assign w_empty_nxt  = (w_count_nxt == '0);
`endif

    // RAM array carries no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[r_wptr[AW-1:0]] <= data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_dout  <= '0;
`ifdef SYNC_FIFO_FWFT_EN
            r_ovalid <= 1'b0;
`endif
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
            r_empty <= w_empty_nxt;
            r_af    <= (w_count_nxt >= C_AF);
            r_ae    <= (w_count_nxt <= C_AE);
            r_ovf   <= r_ovf | (write & r_full);
            r_udf   <= r_udf | (read & r_empty);
            if (w_rd_adv) begin
                r_dout <= r_mem[r_rptr[AW-1:0]];
            end
`ifdef SYNC_FIFO_FWFT_EN
            r_ovalid <= w_ovalid_nxt;
`endif
        end
    end

    assign data_read    = r_dout;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign data_count   = w_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
